// File: rtl/wind_pkg.sv
// Shared Q-format constants and capture FSM encoding for the wind statistics path.
package wind_pkg;

    localparam int WIND_W     = 16;
    localparam int SPEED_FRAC = 10;
    localparam int DIR_FRAC   = 7;

    // Q6.10 speed: 1 m/s; Q9.7 direction: 1 degree
    localparam int ONE_MPS = 1 << SPEED_FRAC;
    localparam int ONE_DEG = 1 << DIR_FRAC;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } cap_state_t;

endpackage

// File: rtl/wind_capture_timer.sv
// Fixed-latency capture timer: counts CORDIC_LAT edges after data_rdy and strobes capture.
module wind_capture_timer
    import wind_pkg::*;
#(
    parameter int CORDIC_LAT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic data_rdy,
    output logic capture,
    output logic overrun_set
);

    localparam int TW = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;
    localparam logic [TW-1:0] LOAD = TW'(CORDIC_LAT - 1);

    cap_state_t    state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        capture     = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (data_rdy) begin
                    timer_nxt = LOAD;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (timer != '0) begin
                    timer_nxt   = timer - TW'(1);
                    overrun_set = data_rdy;
                end else begin
                    // capture edge; a coincident request chains straight into a new wait
                    capture = 1'b1;
                    if (data_rdy) begin
                        timer_nxt = LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/wind_stats.sv
// Block statistics (mean speed, peak gust and its direction) over 2^LOG2N captured samples.
// Optional sticky overrun output is enabled by defining WIND_STATS_OVERRUN_EN.
module wind_stats
    import wind_pkg::*;
#(
    parameter int CORDIC_LAT = 16,
    parameter int LOG2N      = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     data_rdy,
    input  logic signed [WIND_W-1:0] speed,
    input  logic signed [WIND_W-1:0] direction,
    output logic signed [WIND_W-1:0] avg_speed,
    output logic signed [WIND_W-1:0] gust_speed,
    output logic signed [WIND_W-1:0] gust_dir,
    output logic                     stats_rdy,
    output logic [LOG2N-1:0]         sample_count
`ifdef WIND_STATS_OVERRUN_EN
    ,
    output logic                     overrun
`endif
);

    localparam int ACC_W = WIND_W + LOG2N;

    function automatic logic [WIND_W-1:0] clamp_speed(input logic signed [WIND_W-1:0] s);
        return s[WIND_W-1] ? '0 : $unsigned(s);
    endfunction

    logic vld_p0;
    logic ovr_set;

    wind_capture_timer #(
        .CORDIC_LAT(CORDIC_LAT)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .data_rdy   (data_rdy),
        .capture    (vld_p0),
        .overrun_set(ovr_set)
    );

    // Stage p0: clamp the captured sample and form next block state
    logic [WIND_W-1:0]        spd_p0;
    logic                     take_p0;
    logic                     last_p0;
    logic [ACC_W-1:0]         sum_p0;
    logic [WIND_W-1:0]        gust_spd_nxt;
    logic signed [WIND_W-1:0] gust_dir_nxt;

    logic [ACC_W-1:0]         acc_p1;
    logic [WIND_W-1:0]        gust_spd_p1;
    logic signed [WIND_W-1:0] gust_dir_p1;

    always_comb begin
        spd_p0       = clamp_speed(speed);
        // first sample of a block always seeds the gust; ties keep the earlier sample
        take_p0      = (sample_count == '0) || (spd_p0 > gust_spd_p1);
        last_p0      = &sample_count;
        sum_p0       = acc_p1 + {{LOG2N{1'b0}}, spd_p0};
        gust_spd_nxt = take_p0 ? spd_p0 : gust_spd_p1;
        gust_dir_nxt = take_p0 ? direction : gust_dir_p1;
    end

    // Stage p1: accumulator, gust tracking and block outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_p1       <= '0;
            gust_spd_p1  <= '0;
            gust_dir_p1  <= '0;
            sample_count <= '0;
            avg_speed    <= '0;
            gust_speed   <= '0;
            gust_dir     <= '0;
            stats_rdy    <= 1'b0;
        end else begin
            stats_rdy <= 1'b0;
            if (vld_p0) begin
                sample_count <= sample_count + LOG2N'(1);
                if (last_p0) begin
                    avg_speed   <= $signed(sum_p0[ACC_W-1:LOG2N]);
                    gust_speed  <= $signed(gust_spd_nxt);
                    gust_dir    <= gust_dir_nxt;
                    stats_rdy   <= 1'b1;
                    acc_p1      <= '0;
                    gust_spd_p1 <= '0;
                    gust_dir_p1 <= '0;
                end else begin
                    acc_p1      <= sum_p0;
                    gust_spd_p1 <= gust_spd_nxt;
                    gust_dir_p1 <= gust_dir_nxt;
                end
            end
        end
    end

`ifdef WIND_STATS_OVERRUN_EN
    // sticky until the stats pulse; a fresh overrun on that cycle wins
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (stats_rdy) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_ovr;
    assign unused_ovr = ovr_set;
`endif

endmodule

// File: tb/tb_wind_stats.sv
// Scoreboard bench for wind_stats: randomized and directed blocks against a block-level reference model.
module tb_wind_stats;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic data_rdy = 1'b0;
    logic signed [15:0] speed = '0;
    logic signed [15:0] direction = '0;
    logic signed [15:0] avg_speed, gust_speed, gust_dir;
    logic stats_rdy;
    logic [2:0] sample_count;
`ifdef WIND_STATS_OVERRUN_EN
    logic overrun;
`endif

    always #5 clock = ~clock;

    wind_stats #(
        .CORDIC_LAT(16),
        .LOG2N(3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_rdy    (data_rdy),
        .speed       (speed),
        .direction   (direction),
        .avg_speed   (avg_speed),
        .gust_speed  (gust_speed),
        .gust_dir    (gust_dir),
        .stats_rdy   (stats_rdy),
        .sample_count(sample_count)
`ifdef WIND_STATS_OVERRUN_EN
        ,
        .overrun     (overrun)
`endif
    );

    typedef struct {
        int avg;
        int gust;
        int dir;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp = '{0, 0, 0};
    int   blk_s[$];
    int   blk_d[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: keep the raw samples of the block, reduce them when N are present
    function automatic void model_capture(input int s, input int d);
        int sum, g, gd, c;
        exp_t e;
        blk_s.push_back(s);
        blk_d.push_back(d);
        if (blk_s.size() == 8) begin
            sum = 0;
            g   = (blk_s[0] < 0) ? 0 : blk_s[0];
            gd  = blk_d[0];
            for (int i = 0; i < 8; i++) begin
                c = (blk_s[i] < 0) ? 0 : blk_s[i];
                sum += c;
                if (c > g) begin
                    g  = c;
                    gd = blk_d[i];
                end
            end
            e.avg  = sum / 8;
            e.gust = g;
            e.dir  = gd;
            exp_q.push_back(e);
            last_exp = e;
            blk_s.delete();
            blk_d.delete();
        end
    endfunction

    // Monitor: every stats pulse must match the oldest outstanding block result
    logic prev_rdy = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (stats_rdy === 1'b1) begin
            chk("stats_rdy_one_cycle", prev_rdy, 0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_stats_rdy: got pulse, expected none (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("avg_speed", avg_speed, e.avg);
                chk("gust_speed", gust_speed, e.gust);
                chk("gust_dir", gust_dir, e.dir);
            end
        end
        prev_rdy = stats_rdy;
    end

    // One request; speed switches from s0 to s1 at negedge after edge (chg-1), edge 0 = sampled pulse
    task automatic lat(input logic signed [15:0] s0, input logic signed [15:0] s1,
                       input logic signed [15:0] d, input int chg);
        @(negedge clock);
        speed = s0; direction = d; data_rdy = 1'b1;
        @(negedge clock);
        data_rdy = 1'b0;
        for (int pos = 0; pos < 16; pos++) begin
            if (pos == chg - 1) speed = s1;
            if (pos == 15) model_capture((chg <= 16) ? int'(s1) : int'(s0), int'(d));
            @(negedge clock);
        end
        if (chg == 17) speed = s1;
        chk("sample_count", sample_count, blk_s.size());
    endtask

    task automatic cap(input logic signed [15:0] s, input logic signed [15:0] d);
        lat(s, s, d, 1);
    endtask

    task automatic b2b(input logic signed [15:0] s1, input logic signed [15:0] d1,
                       input logic signed [15:0] s2, input logic signed [15:0] d2);
        @(negedge clock);
        speed = s1; direction = d1; data_rdy = 1'b1;
        @(negedge clock);
        data_rdy = 1'b0;
        repeat (15) @(negedge clock);
        data_rdy = 1'b1;
        model_capture(int'(s1), int'(d1));
        @(negedge clock);
        data_rdy = 1'b0; speed = s2; direction = d2;
        chk("b2b_count1", sample_count, blk_s.size());
`ifdef WIND_STATS_OVERRUN_EN
        chk("b2b_no_overrun", overrun, 0);
`endif
        repeat (15) @(negedge clock);
        model_capture(int'(s2), int'(d2));
        @(negedge clock);
        chk("b2b_count2", sample_count, blk_s.size());
    endtask

    task automatic ovr(input logic signed [15:0] s, input logic signed [15:0] d);
        @(negedge clock);
        speed = s; direction = d; data_rdy = 1'b1;
        @(negedge clock);
        data_rdy = 1'b0;
        repeat (8) @(negedge clock);
        data_rdy = 1'b1;
        @(negedge clock);
        data_rdy = 1'b0;
`ifdef WIND_STATS_OVERRUN_EN
        chk("overrun_set", overrun, 1);
`endif
        repeat (6) @(negedge clock);
        model_capture(int'(s), int'(d));
        @(negedge clock);
        chk("ovr_count", sample_count, blk_s.size());
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1; data_rdy = 1'b0;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
        blk_s.delete();
        blk_d.delete();
        last_exp = '{0, 0, 0};
        chk("rst_avg", avg_speed, 0);
        chk("rst_gust", gust_speed, 0);
        chk("rst_dir", gust_dir, 0);
        chk("rst_stats_rdy", stats_rdy, 0);
        chk("rst_count", sample_count, 0);
`ifdef WIND_STATS_OVERRUN_EN
        chk("rst_overrun", overrun, 0);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] rs, rd;
        do_reset(3);

        // latency: switch just before the capture edge vs just after
        lat(16'sd100, 16'sd2048, 16'sd10, 16);
        lat(16'sd100, 16'sd2048, 16'sd20, 17);
        for (int k = 0; k < 6; k++) cap(16'sd0, 16'(k));

        for (int k = 0; k < 8; k++) cap(16'sd1024, 16'sd5760);
        chk("const_count_wrap", sample_count, 0);

        for (int k = 0; k < 8; k++) cap(16'(k * 128), 16'(k * 128));

        cap(-16'sd500, 16'sd50);
        cap(16'sd2000, 16'sd100);
        cap(16'sd2000, 16'sd200);
        for (int k = 0; k < 5; k++) cap(16'sd0, 16'sd300);

        for (int k = 0; k < 5; k++) cap(16'sd3000, 16'sd77);
        do_reset(1);
        for (int k = 0; k < 8; k++) cap(16'sd512, 16'(k));

        // reset during the latency wait discards the pending capture
        @(negedge clock);
        speed = 16'sd999; data_rdy = 1'b1;
        @(negedge clock);
        data_rdy = 1'b0;
        repeat (5) @(negedge clock);
        do_reset(1);
        repeat (20) @(negedge clock);
        chk("rst_wait_count", sample_count, 0);

        b2b(16'sd700, 16'sd1, 16'sd300, 16'sd2);
        ovr(16'sd900, 16'sd3);
        for (int k = 0; k < 5; k++) cap(16'(k * 10), 16'sd4);
`ifdef WIND_STATS_OVERRUN_EN
        chk("overrun_held", overrun, 1);
        @(negedge clock);
        chk("overrun_cleared", overrun, 0);
`endif

        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                rs = 16'($urandom);
                if ($urandom_range(0, 1) == 0) rs = ($urandom_range(0, 2) == 0) ? -16'sd1 : 16'sd1000;
                rd = 16'($urandom);
                cap(rs, rd);
            end
        end

        repeat (5) @(negedge clock);
        chk("hold_avg", avg_speed, last_exp.avg);
        chk("hold_gust", gust_speed, last_exp.gust);
        chk("hold_dir", gust_dir, last_exp.dir);
        chk("pending_results", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
